// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-stage hazard controller:
// forward-select codes, mul/div state encoding and select-width helper.
package pipe_pkg;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // Operand comes straight from the register file.
   localparam int unsigned FWD_RF = 0;

   // Width of the mul/div latency counter (MD_LAT <= 15).
   localparam int MD_CNT_W = 4;

   // Width of the forward-select code for NF forwarding stages.
   function automatic int fw_width(input int nf);
      return $clog2(2 * nf) + 1;
   endfunction

   // Code selecting the ALU result held in stage k.
   function automatic int unsigned fwd_alu(input int unsigned k);
      return k;
   endfunction

   // Code selecting the load data held in stage k (k >= 2).
   function automatic int unsigned fwd_load(input int unsigned nf, input int unsigned k);
      return nf + k;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle of decode-stage hazard signals; master drives the pipeline
// side, slave is the hazard controller side.
interface pipe_hazard_ctl_if
   import pipe_pkg::*;
#(
   parameter int NF = 2,
   parameter int RW = 5
) ();
   localparam int FW = fw_width(NF);

   logic [RW-1:0]    rs;
   logic [RW-1:0]    rt;
   logic             use_rs;
   logic             use_rt;
   logic [NF-1:0]    st_wreg;
   logic [NF-1:0]    st_m2reg;
   logic [NF*RW-1:0] st_rn;
   logic             md_start;
   logic [RW-1:0]    md_rn;
   logic             br_taken;
   logic [FW-1:0]    fwda;
   logic [FW-1:0]    fwdb;
   logic             nostall;
   logic             flush_if;
   logic             md_busy;
   logic             md_done;
   logic [15:0]      stall_cnt;

   modport master (
      output rs, rt, use_rs, use_rt, st_wreg, st_m2reg, st_rn,
             md_start, md_rn, br_taken,
      input  fwda, fwdb, nostall, flush_if, md_busy, md_done, stall_cnt
   );

   modport slave (
      input  rs, rt, use_rs, use_rt, st_wreg, st_m2reg, st_rn,
             md_start, md_rn, br_taken,
      output fwda, fwdb, nostall, flush_if, md_busy, md_done, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctl_fwd_sel.sv
// Per-operand forwarding priority: picks the youngest stage writing
// the operand register and flags a load-use hazard on stage 1.
module fwd_sel
   import pipe_pkg::*;
#(
   parameter int NF = 2,
   parameter int RW = 5,
   parameter int FW = fw_width(NF)
) (
   input  logic [RW-1:0]    rn,
   input  logic             use_r,
   input  logic [NF-1:0]    st_wreg,
   input  logic [NF-1:0]    st_m2reg,
   input  logic [NF*RW-1:0] st_rn,
   output logic [FW-1:0]    fwd,
   output logic             load_use
);

   // Scan oldest to youngest so the youngest matching stage is written last.
   always_comb begin
      fwd      = '0;
      load_use = 1'b0;
      for (int unsigned k = NF; k >= 1; k--) begin
         if (use_r && st_wreg[k-1] &&
             (st_rn[(k-1)*RW +: RW] != '0) &&
             (st_rn[(k-1)*RW +: RW] == rn)) begin
            if (st_m2reg[k-1] && (k == 1)) begin
               fwd      = FW'(FWD_RF);
               load_use = 1'b1;
            end else if (st_m2reg[k-1]) begin
               fwd      = FW'(fwd_load(NF, k));
               load_use = 1'b0;
            end else begin
               fwd      = FW'(fwd_alu(k));
               load_use = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Decode-stage hazard controller: operand forwarding, load-use and
// mul/div stalls, fetch flush on taken branch, stall-cycle counter.
module pipe_hazard_ctl
   import pipe_pkg::*;
#(
   parameter int NF     = 2,
   parameter int MD_LAT = 4,
   parameter int RW     = 5,
   localparam int FW    = fw_width(NF)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RW-1:0]    rs,
   input  logic [RW-1:0]    rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic [NF-1:0]    st_wreg,
   input  logic [NF-1:0]    st_m2reg,
   input  logic [NF*RW-1:0] st_rn,
   input  logic             md_start,
   input  logic [RW-1:0]    md_rn,
   input  logic             br_taken,
   output logic [FW-1:0]    fwda,
   output logic [FW-1:0]    fwdb,
   output logic             nostall,
   output logic             flush_if,
   output logic             md_busy,
   output logic             md_done,
   output logic [15:0]      stall_cnt
);

   localparam logic [MD_CNT_W-1:0] MD_INIT = MD_CNT_W'(MD_LAT - 1);

   md_state_e           state_q, state_d, state_eff;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
   logic [RW-1:0]       md_rn_q, md_rn_d, md_rn_eff;
   logic [15:0]         stall_cnt_q, stall_cnt_d;
   logic                lu_a, lu_b, md_hit, md_hazard;

   fwd_sel #(.NF(NF), .RW(RW), .FW(FW)) u_fwd_a (
      .rn       (rs),
      .use_r    (use_rs),
      .st_wreg  (st_wreg),
      .st_m2reg (st_m2reg),
      .st_rn    (st_rn),
      .fwd      (fwda),
      .load_use (lu_a)
   );

   fwd_sel #(.NF(NF), .RW(RW), .FW(FW)) u_fwd_b (
      .rn       (rt),
      .use_r    (use_rt),
      .st_wreg  (st_wreg),
      .st_m2reg (st_m2reg),
      .st_rn    (st_rn),
      .fwd      (fwdb),
      .load_use (lu_b)
   );

   // Stall/flush decision; while reset is held the MD unit is seen as idle.
   always_comb begin
      state_eff = reset ? MD_IDLE : state_q;
      md_rn_eff = reset ? '0 : md_rn_q;
      md_busy   = (state_eff != MD_IDLE);
      md_done   = (state_eff == MD_DONE);
      md_hit    = (md_rn_eff != '0) &&
                  ((use_rs && (rs == md_rn_eff)) || (use_rt && (rt == md_rn_eff)));
      md_hazard = md_busy && (md_hit || md_start);
      nostall   = !(lu_a || lu_b || md_hazard);
      flush_if  = br_taken && nostall;
   end

   // MD next state; DONE is entered on the cycle the count reaches zero,
   // so BUSY plus DONE spans exactly MD_LAT cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_rn_d = md_rn_q;
      cnt_dec = cnt_q - 1'b1;
      case (state_q)
         MD_IDLE: begin
            if (md_start && nostall) begin
               state_d = MD_BUSY;
               cnt_d   = MD_INIT;
               md_rn_d = md_rn;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) state_d = MD_DONE;
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Saturating count of cycles in which decode is held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!nostall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         md_rn_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_rn_q     <= md_rn_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: stimulus pushes expected
// outputs from a behavioural model, a negedge monitor pops and checks.
module tb_pipe_hazard_ctl;
   import pipe_pkg::*;

   localparam int NF     = 2;
   localparam int MD_LAT = 4;
   localparam int RW     = 5;
   localparam int FW     = fw_width(NF);

   typedef struct {
      int fwda;
      int fwdb;
      int nostall;
      int flush_if;
      int md_busy;
      int md_done;
      int stall_cnt;
   } exp_t;

   logic clock;
   logic reset;
   int   tests  = 0;
   int   failed = 0;
   exp_t sb[$];

   // Model state: cycles left in the current mul/div op, its target, stall count.
   int md_left;
   int md_tgt;
   int stall_model;

   pipe_hazard_ctl_if #(.NF(NF), .RW(RW)) bus ();

   pipe_hazard_ctl #(.NF(NF), .MD_LAT(MD_LAT), .RW(RW)) dut (
      .clock     (clock),
      .reset     (reset),
      .rs        (bus.rs),
      .rt        (bus.rt),
      .use_rs    (bus.use_rs),
      .use_rt    (bus.use_rt),
      .st_wreg   (bus.st_wreg),
      .st_m2reg  (bus.st_m2reg),
      .st_rn     (bus.st_rn),
      .md_start  (bus.md_start),
      .md_rn     (bus.md_rn),
      .br_taken  (bus.br_taken),
      .fwda      (bus.fwda),
      .fwdb      (bus.fwdb),
      .nostall   (bus.nostall),
      .flush_if  (bus.flush_if),
      .md_busy   (bus.md_busy),
      .md_done   (bus.md_done),
      .stall_cnt (bus.stall_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      tests++;
      if (act !== 32'(exp)) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Youngest stage writing register r supplies it; a load there in stage 1 is load-use.
   function automatic int ref_fwd(input int r, input bit use_r, output bit lu);
      int rn_k;
      lu = 1'b0;
      if (!use_r || r == 0) return 0;
      for (int k = 1; k <= NF; k++) begin
         rn_k = int'(bus.st_rn[(k-1)*RW +: RW]);
         if (bus.st_wreg[k-1] && rn_k == r) begin
            if (!bus.st_m2reg[k-1]) return k;
            if (k == 1) begin
               lu = 1'b1;
               return 0;
            end
            return NF + k;
         end
      end
      return 0;
   endfunction

   // One cycle: predict outputs for the current inputs, then advance the model.
   task automatic step();
      exp_t e;
      bit   lua, lub, busy, hit, stall;
      int   tgt;
      e.fwda = ref_fwd(int'(bus.rs), bus.use_rs, lua);
      e.fwdb = ref_fwd(int'(bus.rt), bus.use_rt, lub);
      busy   = !reset && (md_left > 0);
      tgt    = reset ? 0 : md_tgt;
      hit    = (tgt != 0) && ((bus.use_rs && int'(bus.rs) == tgt) ||
                              (bus.use_rt && int'(bus.rt) == tgt));
      stall  = lua || lub || (busy && (hit || bus.md_start));
      e.nostall   = stall ? 0 : 1;
      e.flush_if  = (bus.br_taken && !stall) ? 1 : 0;
      e.md_busy   = busy ? 1 : 0;
      e.md_done   = (!reset && md_left == 1) ? 1 : 0;
      e.stall_cnt = stall_model;
      sb.push_back(e);
      @(posedge clock);
      if (reset) begin
         md_left     = 0;
         md_tgt      = 0;
         stall_model = 0;
      end else begin
         if (md_left > 0) md_left--;
         else if (bus.md_start && !stall) begin
            md_left = MD_LAT;
            md_tgt  = int'(bus.md_rn);
         end
         if (stall && stall_model < 65535) stall_model++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.rs = '0; bus.rt = '0; bus.use_rs = 1'b0; bus.use_rt = 1'b0;
      bus.st_wreg = '0; bus.st_m2reg = '0; bus.st_rn = '0;
      bus.md_start = 1'b0; bus.md_rn = '0; bus.br_taken = 1'b0;
   endtask

   task automatic random_inputs();
      logic [NF*RW-1:0] rn;
      rn = '0;
      for (int k = 0; k < NF; k++) rn[k*RW +: RW] = RW'($urandom_range(0, 7));
      bus.rs       = RW'($urandom_range(0, 7));
      bus.rt       = RW'($urandom_range(0, 7));
      bus.use_rs   = 1'($urandom_range(0, 1));
      bus.use_rt   = 1'($urandom_range(0, 1));
      bus.st_wreg  = NF'($urandom);
      bus.st_m2reg = NF'($urandom);
      bus.st_rn    = rn;
      bus.md_start = ($urandom_range(0, 5) == 0);
      bus.md_rn    = RW'($urandom_range(0, 7));
      bus.br_taken = 1'($urandom_range(0, 1));
      reset        = ($urandom_range(0, 199) == 0);
   endtask

   // Monitor: every cycle the DUT presents a full output set.
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("fwda",      32'(bus.fwda),      e.fwda);
         chk("fwdb",      32'(bus.fwdb),      e.fwdb);
         chk("nostall",   32'(bus.nostall),   e.nostall);
         chk("flush_if",  32'(bus.flush_if),  e.flush_if);
         chk("md_busy",   32'(bus.md_busy),   e.md_busy);
         chk("md_done",   32'(bus.md_done),   e.md_done);
         chk("stall_cnt", 32'(bus.stall_cnt), e.stall_cnt);
      end
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      md_left = 0; md_tgt = 0; stall_model = 0;
      repeat (3) @(posedge clock);
      #1;
      step();
      reset = 1'b0;
      step();

      // Same register in both stages: youngest ALU result wins.
      bus.st_wreg = 2'b11; bus.st_rn = {5'd5, 5'd5}; bus.rs = 5'd5; bus.use_rs = 1'b1;
      step();
      idle_inputs();

      // Load-use on stage 1, then forward the load data from stage 2.
      bus.st_wreg = 2'b01; bus.st_m2reg = 2'b01; bus.st_rn = {5'd0, 5'd8};
      bus.rt = 5'd8; bus.use_rt = 1'b1;
      step();
      bus.st_wreg = 2'b10; bus.st_m2reg = 2'b10; bus.st_rn = {5'd8, 5'd0};
      step();
      idle_inputs();

      // Mul/div to r9 with a dependent instruction waiting in decode.
      bus.md_start = 1'b1; bus.md_rn = 5'd9;
      step();
      bus.md_start = 1'b0; bus.rs = 5'd9; bus.use_rs = 1'b1;
      repeat (6) step();
      idle_inputs();

      // Second mul/div issued while busy, with a taken branch.
      bus.md_start = 1'b1; bus.md_rn = 5'd3;
      step();
      bus.br_taken = 1'b1;
      repeat (5) step();
      idle_inputs();
      step();

      // Reset in the second busy cycle abandons the op.
      bus.md_start = 1'b1; bus.md_rn = 5'd6;
      step();
      bus.md_start = 1'b0; bus.rs = 5'd6; bus.use_rs = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (6) step();
      idle_inputs();

      for (int i = 0; i < 3000; i++) begin
         random_inputs();
         step();
      end
      reset = 1'b0;
      idle_inputs();
      step();

      // Long load-use stall to saturate the counter.
      bus.st_wreg = 2'b01; bus.st_m2reg = 2'b01; bus.st_rn = {5'd0, 5'd4};
      bus.rs = 5'd4; bus.use_rs = 1'b1;
      repeat (70000) step();

      // Register 0 never forwards even when every stage writes it.
      idle_inputs();
      bus.use_rs = 1'b1; bus.use_rt = 1'b1; bus.st_wreg = 2'b11;
      step();
      bus.st_m2reg = 2'b11;
      step();
      bus.br_taken = 1'b1;
      step();
      idle_inputs();

      @(negedge clock);
      @(negedge clock);
      chk("sb_drain", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctl.md
PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 SHALL have parameter NF, default 2, meaning number of forwarding source stages behind decode (stage 1 = EXE, 2 = MEM, 3 = WB); legal 2..3.
REQ-002 SHALL have parameter MD_LAT, default 4, meaning mul/div execution cycles; legal 2..15.
REQ-003 SHALL have parameter RW, default 5, meaning register-number width.
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port rs, rt  in  RW each  decode-stage source registers.
REQ-007 SHALL have port use_rs, use_rt  in  1 each  decode instruction reads rs/rt.
REQ-008 SHALL have port st_wreg  in  NF  per-stage write-enable, bit k-1 = stage k.
REQ-009 SHALL have port st_m2reg  in  NF  per-stage load flag.
REQ-010 SHALL have port st_rn  in  NF*RW  per-stage destination, slice k-1 = stage k.
REQ-011 SHALL have port md_start, md_rn  in  1, RW  decode issues mul/div writing md_rn.
REQ-012 SHALL have port br_taken  in  1  decode resolved branch/jump taken.
REQ-013 SHALL have port fwda, fwdb  out  FW = clog2(2*NF)+1  operand source select.
REQ-014 SHALL have port nostall  out  1  decode may advance; gates wreg/wmem.
REQ-015 SHALL have port flush_if  out  1  squash fetch-stage instruction.
REQ-016 SHALL have port md_busy, md_done  out  1 each  mul/div unit state.
REQ-017 SHALL have port stall_cnt  out  16  saturating stall-cycle counter.

Function
REQ-018 Forward code SHALL be 0 = register file, k = stage-k ALU result, NF+k = stage-k load data (k >= 2 only).
REQ-019 Per operand, youngest matching stage (smallest k) SHALL win; match = st_wreg[k] & st_rn[k] != 0 & st_rn[k] == rs/rt & use_rs/use_rt.
REQ-020 Stage-1 match with st_m2reg[1] SHALL deassert nostall (load-use); fwd code SHALL then be 0.
REQ-021 MD FSM states IDLE, BUSY, DONE; IDLE->BUSY on md_start & nostall, counter loaded MD_LAT-1, md_rn latched.
REQ-022 BUSY SHALL decrement counter each cycle; at count 0 -> DONE; DONE lasts exactly one cycle, md_done = 1, then IDLE.
REQ-023 md_busy SHALL be 1 in BUSY and DONE.
REQ-024 nostall SHALL be 0 when md_busy and decode reads latched md_rn (md_rn != 0), or md_start while md_busy.
REQ-025 flush_if SHALL equal br_taken & nostall (combinational, same cycle).
REQ-026 stall_cnt SHALL increment each cycle nostall = 0, saturating at 0xFFFF.
REQ-027 All combinational outputs SHALL settle same cycle as inputs; MD transitions take effect next edge.

Reset
REQ-028 On reset: FSM IDLE, counter 0, latched md_rn 0, stall_cnt 0, md_busy 0, md_done 0.
REQ-029 Reset mid-BUSY SHALL abandon the operation without an md_done pulse.
REQ-030 Combinational outputs SHALL follow inputs during reset using reset-state MD values.

Structure
REQ-031 Forward-code constants, MD state encodings and FW width function SHALL reside in shared package pipe_pkg.
REQ-032 Per-operand priority forwarding SHALL be one sub-module, fwd_sel, instantiated twice (rs, rt).

Verification
REQ-033 st_wreg=2'b11, st_rn={5,5}, rs=5, no loads -> fwda=1, nostall=1.
REQ-034 Stage-1 lw to r8, rt=8, use_rt=1 -> nostall=0, fwdb=0, stall_cnt +1; next cycle lw in stage 2 -> fwdb=4, nostall=1.
REQ-035 md_start md_rn=9, MD_LAT=4 -> md_busy 4 cycles, md_done in the 4th; decode reading r9 stalls until DONE exits.
REQ-036 Second md_start during BUSY -> nostall=0 until IDLE; br_taken same cycle -> flush_if=0.
REQ-037 reset asserted in 2nd BUSY cycle -> next cycle md_busy=0, md_done never pulses, stall_cnt=0.
REQ-038 Force 70000 stall cycles -> stall_cnt=0xFFFF held; rs=0 with all stages writing r0 -> fwda=0.
